// File: rtl/pixel_pkg.sv
// Shared pixel types and arithmetic for the image pipeline filters.
// Pixels are packed {A,R,G,B}, 8 bits per channel, alpha in the top byte.
// sat_sub8 is the darkening primitive: channel minus amount, clamped at zero.
package pixel_pkg;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  localparam logic [7:0] ALPHA_OPAQUE = 8'hFF;

  function automatic logic [7:0] sat_sub8(input logic [7:0] c, input logic [7:0] b);
    return (c >= b) ? (c - b) : 8'h00;
  endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry skid FIFO; head entry is always in slot 0 and drives dout directly.
// Latency: a push into an empty FIFO is visible on dout the next cycle.
// Backpressure: registered in_ready = room after this cycle, forced low by hold.
module skid_fifo2 #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  input  logic         hold,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] dout
);

  logic [W-1:0] mem0;
  logic [W-1:0] mem1;
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic         rdy_q;
  logic         pop_fire;

  assign pop_fire  = pop && (count_q != 2'd0);
  assign in_ready  = rdy_q;
  assign out_valid = (count_q != 2'd0);
  assign dout      = mem0;

  // Occupancy after this cycle's push/pop; push+pop together leaves it unchanged.
  always_comb begin
    count_d = count_q;
    if (push && !pop_fire) begin
      count_d = count_q + 2'd1;
    end else if (!push && pop_fire) begin
      count_d = count_q - 2'd1;
    end
  end

  // Storage shift, occupancy and the registered ready derived from next occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem0    <= '0;
      mem1    <= '0;
      count_q <= 2'd0;
      rdy_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      rdy_q   <= (count_d < 2'd2) && !hold;
      if (pop_fire) begin
        if (push && (count_q == 2'd1)) begin
          mem0 <= din;
        end else if (count_q == 2'd2) begin
          mem0 <= mem1;
        end
      end else if (push) begin
        if (count_q == 2'd0) begin
          mem0 <= din;
        end else begin
          mem1 <= din;
        end
      end
    end
  end

endmodule

// File: rtl/darkness_filter_stream.sv
// Framed streaming darkening filter: RGB minus per-frame beta (floor 0), alpha forced opaque.
// Latency: 1 cycle from accepted input to out_valid when the skid buffer is empty.
// Backpressure: 2-entry skid buffer; in_ready registered, low when full or draining a frame.
module darkness_filter_stream #(
  parameter int PIXELS_PER_FRAME = 16,
  parameter int CNT_W            = $clog2(PIXELS_PER_FRAME)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pixel,
  input  logic        in_sof,
  input  logic [7:0]  beta,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pixel,
  output logic        out_eof,
  output logic        frame_done,
  output logic        sof_err
);
  import pixel_pkg::*;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PIXELS_PER_FRAME - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       beta_q;
  logic             sof_err_q;
  logic             frame_done_q;
  logic             fire_in;
  logic             push;
  logic             push_eof;
  logic             hold;
  logic             eof_xfer;
  logic [7:0]       b_eff;
  pixel_t           px;
  pixel_t           res;
  logic [32:0]      fifo_dout;
  logic             fifo_vld;
  logic             unused_alpha;

  assign fire_in      = in_valid && in_ready;
  assign eof_xfer     = fifo_vld && out_ready && fifo_dout[32];
  // Keep ready low through DRAIN and the frame_done cycle, giving one bubble between frames.
  assign hold         = (state_q == DRAIN) || (state_d == DRAIN);
  assign px           = in_pixel;
  assign unused_alpha = ^px.a;

  // The SOF beat in IDLE uses the live beta; every later beat uses the latched copy.
  always_comb begin
    b_eff = (state_q == IDLE) ? beta : beta_q;
    res.a = ALPHA_OPAQUE;
    res.r = sat_sub8(px.r, b_eff);
    res.g = sat_sub8(px.g, b_eff);
    res.b = sat_sub8(px.b, b_eff);
  end

  // Frame FSM: next state and push/eof decisions.
  always_comb begin
    state_d  = state_q;
    push     = 1'b0;
    push_eof = 1'b0;
    case (state_q)
      IDLE: begin
        if (fire_in && in_sof) begin
          push    = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (fire_in) begin
          push = 1'b1;
          if (cnt_q == LAST_IDX) begin
            push_eof = 1'b1;
            state_d  = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (eof_xfer) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pixel counter, beta latch, sticky framing error and frame_done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      beta_q       <= 8'h00;
      sof_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= eof_xfer;
      if (fire_in) begin
        if (state_q == IDLE) begin
          if (in_sof) begin
            beta_q <= beta;
            cnt_q  <= CNT_W'(1);
          end else begin
            sof_err_q <= 1'b1;
          end
        end else begin
          if (in_sof) begin
            sof_err_q <= 1'b1;
          end
          cnt_q <= push_eof ? '0 : (cnt_q + 1'b1);
        end
      end
    end
  end

  skid_fifo2 #(.W(33)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .din       ({push_eof, res}),
    .pop       (out_ready),
    .hold      (hold),
    .in_ready  (in_ready),
    .out_valid (fifo_vld),
    .dout      (fifo_dout)
  );

  assign out_valid  = fifo_vld;
  assign out_pixel  = fifo_dout[31:0];
  assign out_eof    = fifo_dout[32];
  assign frame_done = frame_done_q;
  assign sof_err    = sof_err_q;

endmodule

// File: tb/tb_darkness_filter_stream.sv
// Directed bench for darkness_filter_stream with PIXELS_PER_FRAME=4.
// Expected outputs are queued at input acceptance and compared on output transfer.
module tb_darkness_filter_stream;
  localparam int PPF = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pixel;
  logic        in_sof;
  logic [7:0]  beta;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pixel;
  logic        out_eof;
  logic        frame_done;
  logic        sof_err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_fd     = 0;
  int exp_fd   = 0;

  logic [32:0] q[$];
  logic        m_in_frame = 1'b0;
  int          m_cnt      = 0;
  logic [7:0]  m_beta     = 8'h00;

  logic        prev_stall = 1'b0;
  logic        prev_eofx  = 1'b0;
  logic [32:0] prev_dat   = '0;

  darkness_filter_stream #(.PIXELS_PER_FRAME(PPF)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .in_sof     (in_sof),
    .beta       (beta),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pixel  (out_pixel),
    .out_eof    (out_eof),
    .frame_done (frame_done),
    .sof_err    (sof_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] msub(input logic [7:0] c, input logic [7:0] b);
    return (c > b) ? (c - b) : ((c == b) ? 8'h00 : 8'h00);
  endfunction

  // Drive one beat until accepted; the model decides what the DUT should emit.
  task automatic send(input logic [31:0] p, input logic s, input logic [7:0] bv);
    logic        keep;
    logic        eof;
    logic [7:0]  bb;
    int          t;
    keep = 1'b1;
    eof  = 1'b0;
    in_valid = 1'b1;
    in_pixel = p;
    in_sof   = s;
    beta     = bv;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $error("FAIL accept_timeout observed=in_ready_low expected=accept_within_100");
    end else begin
      @(posedge clk);
      #1;
      if (!m_in_frame) begin
        if (s) begin
          m_beta     = bv;
          m_in_frame = 1'b1;
          m_cnt      = 1;
        end else begin
          keep = 1'b0;
        end
      end else begin
        m_cnt++;
        if (m_cnt == PPF) begin
          eof        = 1'b1;
          m_in_frame = 1'b0;
          m_cnt      = 0;
          exp_fd++;
        end
      end
      bb = m_beta;
      if (keep) q.push_back({eof, 8'hFF, msub(p[23:16], bb), msub(p[15:8], bb), msub(p[7:0], bb)});
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_done) begin
        got = 1'b1;
        break;
      end
    end
    chk(tag, got, 1'b1);
    @(posedge clk);
    #1;
    chk({tag, "_count"}, n_fd, exp_fd);
  endtask

  // Output monitor: scoreboard compare, stall stability, frame_done timing.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      prev_eofx  = 1'b0;
    end else begin
      chk("frame_done_timing", frame_done, prev_eofx);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_hold", {out_eof, out_pixel}, prev_dat);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $error("FAIL unexpected_output observed=%0h expected=no_output", {out_eof, out_pixel});
        end else begin
          chk("out_data", {out_eof, out_pixel}, q.pop_front());
        end
      end
      if (frame_done) n_fd++;
      prev_stall = out_valid && !out_ready;
      prev_dat   = {out_eof, out_pixel};
      prev_eofx  = out_valid && out_ready && out_eof;
    end
  end

  initial begin
    int t;
    rst = 1'b1; in_valid = 1'b0; in_pixel = '0; in_sof = 1'b0; beta = 8'h00; out_ready = 1'b1;

    // Reset state while rst is held.
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_pixel", out_pixel, 32'h0);
    chk("rst_out_eof", out_eof, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_sof_err", sof_err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1'b1);

    // 1: zero pixel, one-cycle latency.
    send(32'h00000000, 1'b1, 8'h10);
    @(negedge clk);
    chk("t1_latency", {out_valid, out_pixel}, {1'b1, 32'hFF000000});
    for (int i = 0; i < 3; i++) send(32'h00000000, 1'b0, 8'h10);
    wait_done("t1_frame_done");

    // 2: mixed saturation.
    send(32'hFA2100A4, 1'b1, 8'h10);
    @(negedge clk);
    chk("t2_first", {out_valid, out_eof, out_pixel}, {2'b10, 32'hFF110094});
    for (int i = 0; i < 3; i++) send(32'h11223344, 1'b0, 8'h10);
    wait_done("t2_frame_done");

    // 3: backpressure mid-frame.
    out_ready = 1'b0;
    send(32'h11223344, 1'b1, 8'h10);
    send(32'h50607080, 1'b0, 8'h10);
    @(negedge clk);
    chk("t3_in_ready_full", in_ready, 1'b0);
    chk("t3_head", {out_valid, out_pixel}, {1'b1, 32'hFF122334});
    repeat (4) @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h0F0F0F0F, 1'b0, 8'h10);
    send(32'h10FF1011, 1'b0, 8'h10);
    wait_done("t3_frame_done");

    // 4: beta latched on SOF only.
    send(32'h11223344, 1'b1, 8'h10);
    for (int i = 0; i < 3; i++) send(32'h11223344, 1'b0, 8'hFF);
    wait_done("t4a_frame_done");
    send(32'h80808080, 1'b1, 8'h05);
    @(negedge clk);
    chk("t4b_new_beta", out_pixel, 32'hFF7B7B7B);
    for (int i = 0; i < 3; i++) send(32'h04050607, 1'b0, 8'hFF);
    wait_done("t4b_frame_done");

    // 5: framing errors.
    send(32'h12345678, 1'b0, 8'h10);
    @(negedge clk);
    chk("t5_sof_err", sof_err, 1'b1);
    chk("t5_dropped", out_valid, 1'b0);
    send(32'hAABBCCDD, 1'b1, 8'h20);
    send(32'h01020304, 1'b0, 8'h20);
    send(32'h30303030, 1'b1, 8'h20);
    send(32'h21212121, 1'b0, 8'h20);
    wait_done("t5_frame_done");
    chk("t5_sof_err_sticky", sof_err, 1'b1);

    // 6: reset mid-frame discards buffered pixels.
    out_ready = 1'b0;
    send(32'h44444444, 1'b1, 8'h01);
    send(32'h55555555, 1'b0, 8'h01);
    rst = 1'b1;
    q.delete();
    m_in_frame = 1'b0;
    m_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_out_valid", out_valid, 1'b0);
    chk("t6_sof_err", sof_err, 1'b0);
    out_ready = 1'b1;
    send(32'h66666666, 1'b1, 8'h06);
    for (int i = 0; i < 3; i++) send(32'h03070B0F, 1'b0, 8'h06);
    wait_done("t6_frame_done");

    t = 0;
    while (q.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    chk("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/darkness_filter_stream.md
Name: darkness_filter_stream

Overview:
- Streaming pixel filter that lowers brightness: subtracts `beta` from R, G and B with saturation at 0, and forces alpha to 8'hFF.
- It is the inverse-direction counterpart of the combinational brightness (saturating-add) filter.
- Sits in the image pipeline between the pixel reader and the frame writer.
- Adds frame framing (SOF/EOF), a valid/ready handshake with a 2-entry skid buffer, and per-frame `beta` latching.

Parameters:
- PIXELS_PER_FRAME, 16, pixels per frame; must be >= 2.
- CNT_W, $clog2(PIXELS_PER_FRAME), width of the pixel counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream pixel valid.
- in_ready  output  1  block can accept a pixel this cycle.
- in_pixel  input  32  {A,R,G,B}, 8 bits each, A in [31:24].
- in_sof  input  1  marks the first pixel of a frame; qualified by in_valid.
- beta  input  8  darkening amount; sampled only on an accepted SOF beat.
- out_valid  output  1  output pixel valid.
- out_ready  input  1  downstream accepts the output pixel.
- out_pixel  output  32  filtered pixel {8'hFF, R', G', B'}.
- out_eof  output  1  marks the last pixel of a frame; qualified by out_valid.
- frame_done  output  1  one-cycle pulse when the EOF pixel is accepted downstream.
- sof_err  output  1  sticky flag for a framing violation; cleared only by rst.

Behaviour:
- **Reset** (rst=1 on a clock edge):
  - FSM goes to IDLE; buffer is emptied; counter=0; beta_q=0.
  - Outputs: in_ready=0 during the reset cycle, out_valid=0, out_pixel=0, out_eof=0, frame_done=0, sof_err=0.
  - Reset mid-frame discards all buffered pixels; nothing is flushed downstream.
- **Handshakes:**
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - out_pixel and out_eof stay stable while out_valid=1 and out_ready=0.
- **Buffer:**
  - 2-entry skid FIFO of {pixel, eof}.
  - in_ready is registered and equals (count<2) in STREAM and IDLE; it is 0 in DRAIN.
  - A simultaneous push and pop when full is not possible, because in_ready=0 when full.
  - A simultaneous push and pop at count=1 leaves count=1.
- **Latency:** a pixel accepted in cycle N is presented on out_pixel in cycle N+1 when the buffer was empty and no stall occurs. Full throughput is 1 pixel/cycle.
- **Arithmetic:**
  - Each channel: c' = (c >= b) ? c - b : 8'h00, where b = beta on the SOF beat and beta_q afterwards.
  - Input alpha is ignored; output alpha = 8'hFF.
  - The result is computed before the buffer, so buffered entries hold final values.
- **FSM:**
  - IDLE:
    - in_ready=1 (buffer empty).
    - Accepted beat with in_sof=1: beta_q<=beta, counter<=1, push the pixel, go to STREAM.
    - Accepted beat with in_sof=0: drop the pixel and set sof_err.
  - STREAM:
    - Each accepted beat increments the counter.
    - An accepted beat with in_sof=1 sets sof_err and is processed as an ordinary pixel; beta_q is unchanged.
    - The beat that makes counter == PIXELS_PER_FRAME is pushed with eof=1; counter clears; go to DRAIN.
  - DRAIN:
    - in_ready=0.
    - When the eof entry transfers out: frame_done=1 for that cycle, go to IDLE.
  - Next SOF is accepted at the earliest in the cycle after frame_done. This gives a 1-cycle bubble between frames.
- **beta changes:** changes of `beta` while in STREAM or DRAIN have no effect.
- **frame_done** is registered from the transfer event and is high in the cycle after the EOF transfer. It is high for exactly one cycle per frame.

Decomposition:
- Shared package pixel_pkg:
  - typedef pixel_t as a packed struct {a, r, g, b} of 8 bits each.
  - constant ALPHA_OPAQUE = 8'hFF.
  - function sat_sub8(c, b).
- FSM enum {IDLE, STREAM, DRAIN} is local to the module.
- One sub-module: skid_fifo2. It is parameterized by data width (33 bits: pixel + eof), holds the 2-entry storage and count, and drives registered in_ready.
- The top module holds the FSM, counter, beta_q, arithmetic and sof_err.

Test Plan (PIXELS_PER_FRAME=4):
1. Zero pixel: reset, then SOF beat in_pixel=32'h00000000, beta=8'h10 -> out_pixel=32'hFF000000 one cycle later.
2. Mixed saturation: frame of 4 pixels, first 32'hFA2100A4 with beta=8'h10, remaining 32'h11223344 -> outputs 32'hFF1100_94 (i.e. 32'hFF110094) then 32'hFF122334 ×3. out_eof only on the 4th pixel; frame_done pulses once.
3. Backpressure: out_ready=0 for 5 cycles mid-frame -> in_ready drops after 2 buffered pixels; out_pixel is held stable; no pixel is lost or duplicated; order is preserved.
4. beta latching: change beta from 8'h10 to 8'hFF after SOF -> all 4 pixels use 8'h10; the next frame's SOF with beta=8'h05 uses 8'h05.
5. Framing errors: non-SOF beat in IDLE -> dropped, sof_err=1, no out_valid. SOF in mid-frame -> sof_err stays 1, the pixel is output normally, and the frame still ends after 4 pixels.
6. Reset mid-frame: rst after 2 pixels with out_ready=0 -> next cycle out_valid=0, sof_err=0, and a fresh SOF frame of 4 pixels completes with frame_done.
